// File: rtl/apb_pkg.sv
// Shared APB definitions for the bridge side and the responder side.
// Holds bus widths, the responder FSM state encodings (shared with
// APB_Controller) and a byte-lane merge helper used by the register file.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int STRB_W = 4;

  // Responder FSM encodings. These are plain constants so that older tools
  // and the controller side can use the same values.
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT   = 2'd1;
  localparam logic [ST_W-1:0] ST_ACCESS = 2'd2;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [APB_DW-1:0] strb_merge(input logic [APB_DW-1:0] old_w,
                                                   input logic [APB_DW-1:0] new_w,
                                                   input logic [STRB_W-1:0] strb);
    logic [APB_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 32-bit register storage for apb_slave_regbank.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset; clears every word
//   we_i     write enable, with widx_i / wdata_i / wstrb_i (byte strobes)
//   re_i     read enable for the registered read port, index ridx_i
//   rdata_o  registered read data; 0 in any cycle following re_i=0
// Word 0 reads back as ID_VALUE regardless of what its storage holds.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] widx_i,
  input  logic [APB_DW-1:0]        wdata_i,
  input  logic [STRB_W-1:0]        wstrb_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] ridx_i,
  output logic [APB_DW-1:0]        rdata_o
);

  logic [APB_DW-1:0] mem_q [DEPTH];
  logic [APB_DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= strb_merge(mem_q[widx_i], wdata_i, wstrb_i);
    end
  end

  // The read flop doubles as the prdata output flop, so it returns to zero
  // whenever no read is being presented.
  always_ff @(posedge clk_i) begin
    if (rst_i || !re_i) begin
      rdata_q <= '0;
    end else if (ridx_i == '0) begin
      rdata_q <= ID_VALUE;
    end else begin
      rdata_q <= mem_q[ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB responder holding DEPTH 32-bit registers in a window at BASE_ADDR.
// Inserts WAIT_STATES cycles of pready low per access and reports bad
// accesses (outside the window, misaligned, or a write to read-only word 0)
// on pslverr.
// Ports:
//   hclk, hreset               clock, synchronous active-high reset
//   psel, penable, pwrite      APB control from the bridge
//   paddr, pwdata, pstrb       APB address / write data / byte strobes
//   prdata, pready, pslverr    APB response, all driven straight from flops
//   dbg_state                  current FSM state (ST_* encodings)
// Handshake: an access begins on a setup cycle (psel=1, penable=0) seen in
// IDLE or ACCESS; the address/data/strobes are captured then and never
// re-sampled. The access completes in the single cycle where pready=1, and
// prdata/pslverr are meaningful only in that cycle.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ST_W-1:0]   dbg_state
);

  localparam int              IDX_W     = $clog2(DEPTH);
  localparam logic [31:0]     WIN_BYTES = 32'(DEPTH * 4);
  localparam logic [3:0]      CNT_INIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [ST_W-1:0] ST_AFTER_SETUP = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;

  logic [ST_W-1:0]   state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q, err_q;
  logic [APB_DW-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              pready_q, pslverr_q;

  logic              setup;
  logic [31:0]       offset;
  logic              err_now;
  logic [IDX_W-1:0]  idx_now;
  logic              enter_access;
  logic              acc_err, acc_write;
  logic [IDX_W-1:0]  acc_idx;
  logic              rd_en, wr_en;

  assign setup   = psel && !penable && (state_q == ST_IDLE || state_q == ST_ACCESS);
  // Unsigned wrap makes addresses below the base land far outside the window.
  assign offset  = paddr - BASE_ADDR;
  assign idx_now = paddr[2 +: IDX_W];
  assign err_now = (offset >= WIN_BYTES) || (paddr[1:0] != 2'b00) ||
                   (pwrite && idx_now == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d = ST_AFTER_SETUP;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (!psel)            state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_ACCESS;
        else                  cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        if (setup) begin
          state_d = ST_AFTER_SETUP;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states ACCESS is entered straight from the setup edge,
  // before the capture flops hold the new access, so use the live bus there.
  assign enter_access = (state_d == ST_ACCESS);
  assign acc_err      = setup ? err_now : err_q;
  assign acc_write    = setup ? pwrite  : write_q;
  assign acc_idx      = setup ? idx_now : idx_q;
  assign rd_en        = enter_access && !acc_write && !acc_err;
  // Commit on the edge that ends ACCESS; hreset clears storage that edge anyway.
  assign wr_en        = (state_q == ST_ACCESS) && write_q && !err_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= enter_access;
      pslverr_q <= enter_access && acc_err;
      if (setup) begin
        idx_q   <= idx_now;
        write_q <= pwrite;
        err_q   <= err_now;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
      end
    end
  end

  apb_regfile #(
    .DEPTH    (DEPTH),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk_i   (hclk),
    .rst_i   (hreset),
    .we_i    (wr_en),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .re_i    (rd_en),
    .ridx_i  (acc_idx),
    .rdata_o (prdata)
  );

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank. Two instances share the APB bus:
// u_dut0 with no wait states and u_dut3 with three, each with its own
// psel and reset line.
module tb_apb_slave_regbank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst0, rst3;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [1:0]  st0, st3;

  apb_slave_regbank #(.DEPTH(16), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(0),
                      .ID_VALUE(32'hA9B0_0001)) u_dut0 (
    .hclk(clk), .hreset(rst0), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .dbg_state(st0));

  apb_slave_regbank #(.DEPTH(16), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3),
                      .ID_VALUE(32'hA9B0_0001)) u_dut3 (
    .hclk(clk), .hreset(rst3), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .dbg_state(st3));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One complete APB transfer to DUT 'which' (0 or 3). Returns read data,
  // error flag, latency in cycles from the setup cycle, and the pready cycle.
  task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err,
                      output int lat, output int at);
    int start;
    bit done;
    @(posedge clk); #1;
    psel0 = (which == 0); psel3 = (which == 3);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    start = cyc;
    @(posedge clk); #1;
    penable = 1'b1;
    done = 0; rd = '0; err = 1'b0; lat = -1; at = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      if ((which == 0) ? pready0 : pready3) begin
        rd   = (which == 0) ? prdata0 : prdata3;
        err  = (which == 0) ? pslverr0 : pslverr3;
        lat  = cyc - start;
        at   = cyc;
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("pready_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        err;
  int          lat, at, at_w;
  bit          saw_ready;

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst3 = 1'b0;

    // Reset state
    check("rst_pready0",  {31'b0, pready0},  32'd0);
    check("rst_pslverr0", {31'b0, pslverr0}, 32'd0);
    check("rst_prdata0",  prdata0,           32'd0);
    check("rst_state0",   {30'b0, st0},      32'd0);
    check("rst_pready3",  {31'b0, pready3},  32'd0);
    check("rst_state3",   {30'b0, st3},      32'd0);

    // 1: zero-wait write then read of word 1
    xfer(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, rd, err, lat, at);
    check("t1_wr_lat", 32'(lat), 32'd1);
    check("t1_wr_err", {31'b0, err}, 32'd0);
    idle();
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, err, lat, at);
    check("t1_rd_lat",  32'(lat), 32'd1);
    check("t1_rd_data", rd, 32'hDEAD_BEEF);
    check("t1_rd_err",  {31'b0, err}, 32'd0);
    idle();
    check("t1_prdata_after", prdata0, 32'd0);
    check("t1_pready_after", {31'b0, pready0}, 32'd0);

    // 2: three wait states, read the ID word
    xfer(3, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, err, lat, at);
    check("t2_lat",  32'(lat), 32'd4);
    check("t2_data", rd, 32'hA9B0_0001);
    check("t2_err",  {31'b0, err}, 32'd0);
    idle();

    // 3: byte-lane write over all-ones at word 2
    xfer(0, 1'b1, 32'h8000_0008, 32'hFFFF_FFFF, 4'hF, rd, err, lat, at);
    idle();
    xfer(0, 1'b1, 32'h8000_0008, 32'h1122_3344, 4'b0101, rd, err, lat, at);
    idle();
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, rd, err, lat, at);
    check("t3_data", rd, 32'hFF22_FF44);
    idle();
    // all-zero strobes leave word 1 untouched
    xfer(0, 1'b1, 32'h8000_0004, 32'h0000_0000, 4'h0, rd, err, lat, at);
    check("t3_strb0_err", {31'b0, err}, 32'd0);
    idle();
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, rd, err, lat, at);
    check("t3_strb0_data", rd, 32'hDEAD_BEEF);
    idle();

    // 4: error responses
    xfer(0, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, rd, err, lat, at);
    check("t4_wr0_err", {31'b0, err}, 32'd1);
    check("t4_wr0_lat", 32'(lat), 32'd1);
    idle();
    xfer(0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, err, lat, at);
    check("t4_oow_err",  {31'b0, err}, 32'd1);
    check("t4_oow_data", rd, 32'd0);
    idle();
    xfer(0, 1'b0, 32'h8000_0006, 32'h0, 4'h0, rd, err, lat, at);
    check("t4_misal_err",  {31'b0, err}, 32'd1);
    check("t4_misal_data", rd, 32'd0);
    idle();
    xfer(0, 1'b1, 32'h7FFF_FFFC, 32'h0, 4'hF, rd, err, lat, at);
    check("t4_below_err", {31'b0, err}, 32'd1);
    idle();
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, err, lat, at);
    check("t4_id_data", rd, 32'hA9B0_0001);
    check("t4_id_err",  {31'b0, err}, 32'd0);
    idle();

    // 5: back-to-back write then read, no idle between
    xfer(0, 1'b1, 32'h8000_0014, 32'h0BAD_F00D, 4'hF, rd, err, lat, at);
    at_w = at;
    xfer(0, 1'b0, 32'h8000_0014, 32'h0, 4'h0, rd, err, lat, at);
    check("t5_gap",  32'(at - at_w), 32'd2);
    check("t5_data", rd, 32'h0BAD_F00D);
    idle();

    // 6: reset during WAIT of a write to word 3 on the wait-state instance
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8000_000C; pwdata = 32'h5A5A_5A5A; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    check("t6_in_wait", {30'b0, st3}, 32'd1);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    check("t6_rst_state",  {30'b0, st3},     32'd0);
    check("t6_rst_pready", {31'b0, pready3}, 32'd0);
    saw_ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (pready3) saw_ready = 1;
      @(posedge clk); #1;
    end
    check("t6_no_pready", {31'b0, saw_ready}, 32'd0);
    idle();
    xfer(3, 1'b0, 32'h8000_000C, 32'h0, 4'h0, rd, err, lat, at);
    check("t6_word3",   rd, 32'd0);
    check("t6_rd_lat",  32'(lat), 32'd4);
    idle();
    xfer(3, 1'b1, 32'h8000_000C, 32'h5A5A_5A5A, 4'hF, rd, err, lat, at);
    check("t6_wr_err", {31'b0, err}, 32'd0);
    idle();
    xfer(3, 1'b0, 32'h8000_000C, 32'h0, 4'h0, rd, err, lat, at);
    check("t6_word3_after", rd, 32'h5A5A_5A5A);
    idle();

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
